// File: rtl/cic_decimator_n.sv
// N-stage CIC decimator with run-time selectable ratio R = 2^rate_log2.
// The gain is normalised exactly by an arithmetic shift of N*k with round-half-up.
// The result is saturated to the input range and left-justified on data_out.
// The first STAGES comb outputs after a flush are warm-up transients and are suppressed.
// Ports:
//   clk, rst     - clock, synchronous active-high reset
//   in_valid     - qualifies data_in; integrators and phase advance only on it
//   data_in      - signed input sample
//   rate_log2    - requested decimation exponent k, clamped to RATE_LOG2_MAX
//   rate_load    - one-cycle pulse: latch rate_log2 and flush the filter
//   data_out     - signed decimated sample, held between out_valid pulses
//   out_valid    - one-cycle strobe marking a new data_out
//   rate_active  - currently latched k
module cic_decimator_n #(
    parameter int unsigned DATA_WIDTH_I  = 12,
    parameter int unsigned DATA_WIDTH_O  = 16,
    parameter int unsigned STAGES        = 4,
    parameter int unsigned RATE_LOG2_MAX = 6
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   in_valid,
    input  logic signed [DATA_WIDTH_I-1:0]         data_in,
    input  logic [$clog2(RATE_LOG2_MAX+1)-1:0]     rate_log2,
    input  logic                                   rate_load,
    output logic signed [DATA_WIDTH_O-1:0]         data_out,
    output logic                                   out_valid,
    output logic [$clog2(RATE_LOG2_MAX+1)-1:0]     rate_active
);

    localparam int unsigned REG_W = DATA_WIDTH_I + STAGES * RATE_LOG2_MAX;
    localparam int unsigned K_W   = $clog2(RATE_LOG2_MAX + 1);
    localparam int unsigned PH_W  = (RATE_LOG2_MAX > 0) ? RATE_LOG2_MAX : 1;
    localparam int unsigned SH_W  = (STAGES * RATE_LOG2_MAX > 0) ?
                                    $clog2(STAGES * RATE_LOG2_MAX + 1) : 1;
    localparam int unsigned WU_W  = $clog2(STAGES + 1);

    // Saturation bounds of the DATA_WIDTH_I signed range, held at REG_W+1 bits
    localparam logic signed [REG_W:0] SAT_MAX =
        {{(REG_W - DATA_WIDTH_I + 2){1'b0}}, {(DATA_WIDTH_I - 1){1'b1}}};
    localparam logic signed [REG_W:0] SAT_MIN =
        {{(REG_W - DATA_WIDTH_I + 2){1'b1}}, {(DATA_WIDTH_I - 1){1'b0}}};

    logic signed [REG_W-1:0]        integ_q [STAGES];
    logic signed [REG_W-1:0]        integ_d [STAGES];
    // Index 0 is the decimated capture register, 1..STAGES are comb outputs
    logic signed [REG_W-1:0]        comb_q  [STAGES+1];
    logic signed [REG_W-1:0]        comb_d  [STAGES+1];
    logic [STAGES:0]                comb_v_q, comb_v_d;
    logic signed [REG_W-1:0]        dly_q   [STAGES];
    logic signed [REG_W-1:0]        dly_d   [STAGES];
    logic [PH_W-1:0]                phase_q, phase_d;
    logic [WU_W-1:0]                warm_q, warm_d;
    logic signed [REG_W:0]          round_q, round_d;
    logic                           round_v_q, round_v_d;
    logic signed [DATA_WIDTH_O-1:0] data_out_q, data_out_d;
    logic                           out_valid_q, out_valid_d;
    logic [K_W-1:0]                 rate_active_q, rate_active_d;

    logic [K_W-1:0]                 k_clamp_c;
    logic [PH_W-1:0]                last_phase_c;
    logic [SH_W-1:0]                shift_c;
    logic signed [REG_W:0]          rnd_c;
    logic signed [REG_W:0]          sum_c;
    logic [DATA_WIDTH_I-1:0]        sat_c;

    // Rate decode, rounding offset and saturation of the rounded value
    always_comb begin
        k_clamp_c    = (rate_log2 > K_W'(RATE_LOG2_MAX)) ? K_W'(RATE_LOG2_MAX) : rate_log2;
        last_phase_c = PH_W'((32'd1 << rate_active_q) - 32'd1);
        shift_c      = SH_W'(STAGES * rate_active_q);
        rnd_c        = (shift_c == '0) ? '0 :
                       ((REG_W+1)'(1) << (shift_c - SH_W'(1)));
        sum_c        = (REG_W+1)'(comb_q[STAGES]) + rnd_c;
        if (round_q > SAT_MAX) begin
            sat_c = {1'b0, {(DATA_WIDTH_I - 1){1'b1}}};
        end else if (round_q < SAT_MIN) begin
            sat_c = {1'b1, {(DATA_WIDTH_I - 1){1'b0}}};
        end else begin
            sat_c = round_q[DATA_WIDTH_I-1:0];
        end
    end

    // Next-state logic: rate_load flushes, otherwise integrate / decimate / comb / normalise
    always_comb begin
        for (int i = 0; i < STAGES; i++) begin
            integ_d[i] = integ_q[i];
            dly_d[i]   = dly_q[i];
        end
        for (int i = 0; i <= STAGES; i++) begin
            comb_d[i] = comb_q[i];
        end
        comb_v_d      = '0;
        phase_d       = phase_q;
        warm_d        = warm_q;
        round_d       = round_q;
        round_v_d     = 1'b0;
        data_out_d    = data_out_q;
        out_valid_d   = 1'b0;
        rate_active_d = rate_active_q;

        if (rate_load) begin
            for (int i = 0; i < STAGES; i++) begin
                integ_d[i] = '0;
                dly_d[i]   = '0;
            end
            for (int i = 0; i <= STAGES; i++) begin
                comb_d[i] = '0;
            end
            phase_d       = '0;
            warm_d        = '0;
            round_d       = '0;
            rate_active_d = k_clamp_c;
        end else begin
            if (in_valid) begin
                // Each integrator accumulates the previous value of the one before it
                integ_d[0] = integ_q[0] + REG_W'(data_in);
                for (int i = 1; i < STAGES; i++) begin
                    integ_d[i] = integ_q[i] + integ_q[i-1];
                end
                if (phase_q == last_phase_c) begin
                    phase_d     = '0;
                    comb_d[0]   = integ_d[STAGES-1];
                    comb_v_d[0] = 1'b1;
                end else begin
                    phase_d = phase_q + PH_W'(1);
                end
            end

            for (int i = 1; i <= STAGES; i++) begin
                if (comb_v_q[i-1]) begin
                    comb_d[i]  = comb_q[i-1] - dly_q[i-1];
                    dly_d[i-1] = comb_q[i-1];
                end
                comb_v_d[i] = comb_v_q[i-1];
            end

            // Warm-up: swallow the first STAGES comb outputs after a flush
            if (comb_v_q[STAGES]) begin
                if (warm_q == WU_W'(STAGES)) begin
                    round_d   = sum_c >>> shift_c;
                    round_v_d = 1'b1;
                end else begin
                    warm_d = warm_q + WU_W'(1);
                end
            end

            out_valid_d = round_v_q;
            if (round_v_q) begin
                data_out_d = DATA_WIDTH_O'(sat_c) << (DATA_WIDTH_O - DATA_WIDTH_I);
            end
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) begin
                integ_q[i] <= '0;
                dly_q[i]   <= '0;
            end
            for (int i = 0; i <= STAGES; i++) begin
                comb_q[i] <= '0;
            end
            comb_v_q      <= '0;
            phase_q       <= '0;
            warm_q        <= '0;
            round_q       <= '0;
            round_v_q     <= 1'b0;
            data_out_q    <= '0;
            out_valid_q   <= 1'b0;
            rate_active_q <= k_clamp_c;
        end else begin
            for (int i = 0; i < STAGES; i++) begin
                integ_q[i] <= integ_d[i];
                dly_q[i]   <= dly_d[i];
            end
            for (int i = 0; i <= STAGES; i++) begin
                comb_q[i] <= comb_d[i];
            end
            comb_v_q      <= comb_v_d;
            phase_q       <= phase_d;
            warm_q        <= warm_d;
            round_q       <= round_d;
            round_v_q     <= round_v_d;
            data_out_q    <= data_out_d;
            out_valid_q   <= out_valid_d;
            rate_active_q <= rate_active_d;
        end
    end

    assign data_out    = data_out_q;
    assign out_valid   = out_valid_q;
    assign rate_active = rate_active_q;

endmodule

// File: tb/tb_cic_decimator_n.sv
// Bench for cic_decimator_n at default parameters (N=4, 12-bit in, 16-bit out, k up to 6).
// A sample-level CIC model computes each expected decimated output and its due cycle
// when the stimulus is driven; a negedge monitor pops and compares when out_valid fires.
module tb_cic_decimator_n;

    localparam int N     = 4;
    localparam int K_MAX = 6;
    localparam int LAT   = N + 2;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic signed [11:0] data_in;
    logic [2:0]         rate_log2;
    logic               rate_load;
    logic signed [15:0] data_out;
    logic               out_valid;
    logic [2:0]         rate_active;

    always #5 clk = ~clk;

    cic_decimator_n dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .data_in     (data_in),
        .rate_log2   (rate_log2),
        .rate_load   (rate_load),
        .data_out    (data_out),
        .out_valid   (out_valid),
        .rate_active (rate_active)
    );

    typedef struct {
        longint val;
        int     cyc;
    } exp_t;

    exp_t   sb[$];
    int     n_checks = 0;
    int     n_err    = 0;
    int     cyc      = 0;
    bit     mon_en   = 1'b0;
    int     rst_edge = -1;
    longint hold_exp = 0;
    longint last_out = 0;
    int     out_cnt  = 0;
    int     acc      = 0;

    longint m_integ [N];
    longint m_dly   [N];
    int     m_phase;
    int     m_k;
    int     m_dec;

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic longint wrap36(input longint a);
        logic signed [35:0] t;
        t = a[35:0];
        return longint'(t);
    endfunction

    function automatic longint norm(input longint c, input int k);
        int     s;
        longint y;
        s = N * k;
        y = c;
        if (s > 0) y = (c + (longint'(1) <<< (s - 1))) >>> s;
        if (y > 2047)  y = 2047;
        if (y < -2048) y = -2048;
        return y * 16;
    endfunction

    function automatic int clampk(input int k);
        return (k > K_MAX) ? K_MAX : k;
    endfunction

    task automatic model_flush(input int k);
        for (int i = 0; i < N; i++) begin
            m_integ[i] = 0;
            m_dly[i]   = 0;
        end
        m_phase = 0;
        m_dec   = 0;
        m_k     = k;
        sb.delete();
    endtask

    task automatic model_sample(input longint x, input int edge_no);
        longint v, t;
        for (int i = N - 1; i > 0; i--) m_integ[i] = wrap36(m_integ[i] + m_integ[i-1]);
        m_integ[0] = wrap36(m_integ[0] + x);
        if (m_phase == (1 << m_k) - 1) begin
            m_phase = 0;
            v = m_integ[N-1];
            for (int i = 0; i < N; i++) begin
                t        = wrap36(v - m_dly[i]);
                m_dly[i] = v;
                v        = t;
            end
            if (m_dec >= N) sb.push_back('{val: norm(v, m_k), cyc: edge_no + LAT});
            m_dec++;
        end else begin
            m_phase++;
        end
    endtask

    // Drive one clock's worth of inputs and update the model for the edge that samples them
    task automatic step(input logic v, input longint x, input logic ld, input int k, input logic r);
        int e;
        in_valid  = v;
        data_in   = 12'(x);
        rate_load = ld;
        rate_log2 = 3'(k);
        rst       = r;
        e = cyc + 1;
        if (r) begin
            model_flush(clampk(k));
            rst_edge = e;
        end else if (ld) begin
            model_flush(clampk(k));
        end else if (v) begin
            model_sample(longint'(data_in), e);
            acc++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 0, 1'b0, 0, 1'b0);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: timing, data, missing strobes and hold between strobes
    always @(negedge clk) begin : mon
        exp_t e;
        if (mon_en) begin
            if (rst_edge == cyc) hold_exp = 0;
            if (out_valid) begin
                if (sb.size() == 0) begin
                    check("spurious_valid", longint'(out_valid), 0);
                end else begin
                    e = sb.pop_front();
                    check("out_timing", cyc, e.cyc);
                    check("out_data", longint'(data_out), e.val);
                end
                hold_exp = longint'(data_out);
                last_out = longint'(data_out);
                out_cnt++;
            end else begin
                if (sb.size() > 0 && sb[0].cyc <= cyc) begin
                    check("missing_valid", longint'(out_valid), 1);
                    void'(sb.pop_front());
                end
                check("hold", longint'(data_out), hold_exp);
            end
        end
    end

    initial begin : main
        int     c0, n_exp;
        longint h;

        in_valid = 1'b0; data_in = '0; rate_load = 1'b0; rate_log2 = 3'd3; rst = 1'b1;
        model_flush(3);
        step(1'b0, 0, 1'b0, 3, 1'b1);
        step(1'b0, 0, 1'b0, 3, 1'b1);
        mon_en = 1'b1;
        check("rst_out_valid", longint'(out_valid), 0);
        check("rst_data_out", longint'(data_out), 0);
        check("rst_rate_active", longint'(rate_active), 3);

        // DC at k=3: 8 decimations, 4 suppressed, then 1000*2^12/2^12 << 4
        c0 = out_cnt;
        for (int i = 0; i < 64; i++) step(1'b1, 1000, 1'b0, 3, 1'b0);
        idle(LAT + 4);
        check("dc_value", last_out, 16000);
        check("dc_count", out_cnt - c0, 4);

        // Clamp k=7 to 6, negative then positive full scale
        step(1'b0, 0, 1'b1, 7, 1'b0);
        check("clamp_rate_active", longint'(rate_active), 6);
        for (int i = 0; i < 64 * 6; i++) step(1'b1, -2048, 1'b0, 6, 1'b0);
        idle(LAT + 4);
        check("neg_full_scale", last_out, -32768);
        step(1'b0, 0, 1'b1, 6, 1'b0);
        for (int i = 0; i < 64 * 6; i++) step(1'b1, 2047, 1'b0, 6, 1'b0);
        idle(LAT + 4);
        check("pos_full_scale", last_out, 32752);

        // Passthrough k=0 with random samples
        step(1'b0, 0, 1'b1, 0, 1'b0);
        check("pt_rate_active", longint'(rate_active), 0);
        c0 = out_cnt;
        for (int i = 0; i < 40; i++) step(1'b1, longint'($urandom_range(0, 4095)), 1'b0, 0, 1'b0);
        idle(LAT + 4);
        check("pt_count", out_cnt - c0, 36);

        // Gapped input at k=2
        step(1'b0, 0, 1'b1, 2, 1'b0);
        c0  = out_cnt;
        acc = 0;
        for (int i = 0; i < 240; i++)
            step(1'($urandom_range(0, 1)), longint'($urandom_range(0, 4095)), 1'b0, 2, 1'b0);
        idle(LAT + 4);
        n_exp = acc / 4 - N;
        if (n_exp < 0) n_exp = 0;
        check("gap_count", out_cnt - c0, n_exp);

        // Rate change 2 -> 5 mid-stream, load cycle carries a dropped valid sample
        step(1'b0, 0, 1'b1, 2, 1'b0);
        for (int i = 0; i < 4 * 7; i++) step(1'b1, 500, 1'b0, 2, 1'b0);
        h = longint'(data_out);
        step(1'b1, 1234, 1'b1, 5, 1'b0);
        check("rc_valid_0", longint'(out_valid), 0);
        check("rc_hold_0", longint'(data_out), h);
        check("rc_rate_active", longint'(rate_active), 5);
        step(1'b1, 500, 1'b0, 5, 1'b0);
        check("rc_valid_1", longint'(out_valid), 0);
        check("rc_hold_1", longint'(data_out), h);
        c0 = out_cnt;
        for (int i = 0; i < 32 * 5 - 1; i++) step(1'b1, 500, 1'b0, 5, 1'b0);
        idle(LAT + 4);
        check("rc_no_early_out", out_cnt - c0, 1);
        for (int i = 0; i < 32 * 2; i++) step(1'b1, 500, 1'b0, 5, 1'b0);
        idle(LAT + 4);
        check("rc_dc_value", last_out, 8000);

        // Reset mid-block at phase 3 of k=3
        step(1'b0, 0, 1'b1, 3, 1'b0);
        for (int i = 0; i < 8 * 5 + 3; i++)
            step(1'b1, longint'($urandom_range(0, 4095)), 1'b0, 3, 1'b0);
        step(1'b1, 77, 1'b0, 3, 1'b1);
        check("mid_rst_valid", longint'(out_valid), 0);
        check("mid_rst_data", longint'(data_out), 0);
        check("mid_rst_rate", longint'(rate_active), 3);
        for (int i = 0; i < 160; i++)
            step(1'($urandom_range(0, 1)), longint'($urandom_range(0, 4095)), 1'b0, 3, 1'b0);
        idle(LAT + 4);
        check("sb_drained", longint'(sb.size()), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
